// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, scan FSM state encodings and the shared nibble decoder.
package seg7_pkg;

  // Segment bit order is {a,b,c,d,e,f,g,dp}; codes carry dp=0.
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_0   = 8'hFC;
  localparam logic [7:0] SEG_1   = 8'h60;
  localparam logic [7:0] SEG_2   = 8'hDA;
  localparam logic [7:0] SEG_3   = 8'hF2;
  localparam logic [7:0] SEG_4   = 8'h66;
  localparam logic [7:0] SEG_5   = 8'hB6;
  localparam logic [7:0] SEG_6   = 8'hBE;
  localparam logic [7:0] SEG_7   = 8'hE4;
  localparam logic [7:0] SEG_8   = 8'hFE;
  localparam logic [7:0] SEG_9   = 8'hF6;
  localparam logic [7:0] SEG_A   = 8'hEE;
  localparam logic [7:0] SEG_B   = 8'h3E;
  localparam logic [7:0] SEG_C   = 8'h9C;
  localparam logic [7:0] SEG_D   = 8'h7A;
  localparam logic [7:0] SEG_E   = 8'h9E;
  localparam logic [7:0] SEG_F   = 8'h8E;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  function automatic logic [7:0] seg7_decode_fn(input logic [3:0] nib, input logic dp,
                                                input logic hex_mode);
    logic [7:0] s;
    s = SEG_OFF;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_OFF;
    endcase
    if (!hex_mode && (nib > 4'h9)) s = SEG_OFF;
    return {s[7:1], dp};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble + dp to 8-bit active-high segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       hex_mode_i,
  output logic [7:0] seg_o
);

  assign seg_o = seg7_decode_fn(nib_i, dp_i, hex_mode_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with double-buffered digits.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
//   state | meaning
//   IDLE  | display dark, waiting for enable
//   BLANK | all-off gap before the next digit
//   SHOW  | digit idx lit for SCAN_DIV cycles
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 8,
  parameter int HEX_MODE       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [1:0]    ST_GAP     = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam logic          HEX_EN     = (HEX_MODE != 0);
  localparam logic [7:0]    SEG_XOR    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_XOR = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic       show_last, boundary, show_on, lead_blank, cur_dp;
  logic [3:0] cur_nib;
  logic [7:0] dec_seg;

  assign show_last = (cnt_q == SHOW_LAST);
  assign boundary  = enable && (state_q == ST_SHOW) && show_last && (idx_q == IDX_LAST);
  assign show_on   = enable && (state_q == ST_SHOW);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_last) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Active buffer only moves at a frame boundary (or while dark) so a frame never tears.
  always_comb begin
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if ((state_q == ST_IDLE) && load) begin
      act_dig_d  = digits;
      act_dp_d   = dp_in;
      pend_vld_d = 1'b0;
    end else if (boundary) begin
      if (load) begin
        act_dig_d = digits;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_dig_d = digits;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  assign cur_nib = act_dig_q[{idx_q, 2'b00} +: 4];
  assign cur_dp  = act_dp_q[idx_q];

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run   = run && (act_dig_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      lz[i] = run;
    end
  end
  assign lead_blank = (idx_q != '0) && lz[idx_q];
`else
  assign lead_blank = 1'b0;
`endif

  seg7_decode u_dec (
    .nib_i      (cur_nib),
    .dp_i       (cur_dp),
    .hex_mode_i (HEX_EN),
    .seg_o      (dec_seg)
  );

  assign seg_d = (show_on && !lead_blank) ? dec_seg : SEG_OFF;
  assign an_d  = show_on ? (AN_ONE << idx_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign seg        = seg_q ^ SEG_XOR;
  assign an         = an_q ^ AN_XOR;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for the 4-digit scan driver, hex and non-hex decode.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n, enable, load;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [7:0]  seg, seg_h0;
  logic [3:0]  an, an_h0;
  logic        frame_done, fd_h0;
  logic [25:0] obs;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits(digits),
    .dp_in(dp_in), .seg(seg), .an(an), .frame_done(frame_done));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .digits(digits),
    .dp_in(dp_in), .seg(seg_h0), .an(an_h0), .frame_done(fd_h0));

  assign obs = {an, an_h0, seg, seg_h0, frame_done, fd_h0};

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    checks++;
    assert (got === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan frame: per digit one off cycle then four lit cycles; optional loads at cycles la/lb.
  task automatic frame(input string tag, input logic [31:0] segs, input logic [31:0] segs_h0,
                       input int ncyc, input int la, input logic [15:0] lva,
                       input int lb, input logic [15:0] lvb);
    logic [25:0] e;
    logic [3:0]  ae;
    int k, j;
    for (int c = 0; c < ncyc; c++) begin
      k = c / 5;
      j = c % 5;
      if (c == la) begin
        digits = lva; load = 1'b1;
      end else if (c == lb) begin
        digits = lvb; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
      ae = 4'b0001 << k;
      if (j == 0) e = '0;
      else e = {ae, ae, segs[8*k +: 8], segs_h0[8*k +: 8], (c == 19), (c == 19)};
      check($sformatf("%s_c%0d", tag, c), obs, e);
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; load = 1'b0; digits = '0; dp_in = '0;
    #2 rst_n = 1'b0;
    #2 check("reset", obs, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle", obs, '0);

    digits = 16'h1234; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    check("enable_blank", obs, '0);
    frame("f1_1234", {8'h60, 8'hDA, 8'hF2, 8'h66}, {8'h60, 8'hDA, 8'hF2, 8'h66}, 20, -1, 16'h0, -1, 16'h0);
    frame("f2_hold", {8'h60, 8'hDA, 8'hF2, 8'h66}, {8'h60, 8'hDA, 8'hF2, 8'h66}, 20, 7, 16'h5678, -1, 16'h0);
    dp_in = 4'b0101;
    frame("f3_5678", {8'hB6, 8'hBE, 8'hE4, 8'hFE}, {8'hB6, 8'hBE, 8'hE4, 8'hFE}, 20, 3, 16'h1111, 19, 16'h9ABC);
    frame("f4_9abc", {8'hF6, 8'hEF, 8'h3E, 8'h9D}, {8'hF6, 8'h01, 8'h00, 8'h01}, 13, -1, 16'h0, -1, 16'h0);

    enable = 1'b0;
    tick();
    check("disable_off", obs, '0);
    tick();
    check("idle_off", obs, '0);
    enable = 1'b1;
    tick();
    check("reenable_blank", obs, '0);
    frame("f5_restart", {8'hF6, 8'hEF, 8'h3E, 8'h9D}, {8'hF6, 8'h01, 8'h00, 8'h01}, 20, -1, 16'h0, -1, 16'h0);
    frame("f6_prerst", {8'hF6, 8'hEF, 8'h3E, 8'h9D}, {8'hF6, 8'h01, 8'h00, 8'h01}, 3, -1, 16'h0, -1, 16'h0);

    #2 rst_n = 1'b0;
    #2 check("async_reset", obs, '0);
    #2 rst_n = 1'b1;
    tick();
    check("post_reset_blank", obs, '0);
`ifdef SEG7_LZB_EN
    frame("f7_zero", {8'h00, 8'h00, 8'h00, 8'hFC}, {8'h00, 8'h00, 8'h00, 8'hFC}, 20, -1, 16'h0, -1, 16'h0);
`else
    frame("f7_zero", {8'hFC, 8'hFC, 8'hFC, 8'hFC}, {8'hFC, 8'hFC, 8'hFC, 8'hFC}, 20, -1, 16'h0, -1, 16'h0);
`endif

    enable = 1'b0;
    tick();
    check("disable2_off", obs, '0);
    digits = 16'h0070; dp_in = 4'b0000; load = 1'b1; enable = 1'b1;
    tick();
    load = 1'b0;
    check("idle_load_blank", obs, '0);
    dp_in = 4'b1000;
`ifdef SEG7_LZB_EN
    frame("f8_0070", {8'h00, 8'h00, 8'hE4, 8'hFC}, {8'h00, 8'h00, 8'hE4, 8'hFC}, 20, 0, 16'h0070, -1, 16'h0);
`else
    frame("f8_0070", {8'hFC, 8'hFC, 8'hE4, 8'hFC}, {8'hFC, 8'hFC, 8'hE4, 8'hFC}, 20, 0, 16'h0070, -1, 16'h0);
`endif
    frame("f9_dp3", {8'hFD, 8'hFC, 8'hE4, 8'hFC}, {8'hFD, 8'hFC, 8'hE4, 8'hFC}, 20, -1, 16'h0, -1, 16'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver. Time-multiplexes NUM_DIGITS nibbles onto one shared segment bus with per-digit enables, a blanking gap between digits, double-buffered loading and selectable output polarity. Sits between the datapath (BCD/hex values) and the board display pins, and replaces per-digit combinational decoders.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
SCAN_DIV, 50000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 8, all-off cycles between digits (>=0; 0 skips BLANK)
HEX_MODE, 1, 1: decode 10-15 as A-F; 0: blank for 10-15
SEG_ACTIVE_LOW, 0, 1: invert seg output
AN_ACTIVE_LOW, 1, 1: invert an output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1: scan; 0: display dark
load  in  1  capture digits/dp_in into pending buffer this cycle
digits  in  4*NUM_DIGITS  nibble i = digits[4i+3:4i]; i=0 is least significant
dp_in  in  NUM_DIGITS  decimal point per digit
seg  out  8  {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, active-high before polarity
an  out  NUM_DIGITS  one-hot digit enable, before polarity
frame_done  out  1  one-cycle pulse per completed scan frame

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0, counter=0, active/pending buffers=0, pending_valid=0, seg=all-off, an=all-off, frame_done=0. Takes effect immediately mid-scan; release resumes at IDLE.
- All outputs registered; "off" means 0 before polarity inversion.
- Decode (0-F): 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100100, 11111110, 11110110, 11101110, 00111110, 10011100, 01111010, 10011110, 10001110; seg[0] = active dp bit. With HEX_MODE=0, codes 10-15 give 0000000 with dp still honoured.
- FSM:
  IDLE: outputs off; enable=1 -> BLANK (SHOW if BLANK_CYCLES=0), idx=0, counter=0.
  BLANK: outputs off for BLANK_CYCLES cycles, then SHOW.
  SHOW: an=one-hot(idx), seg=decode(active[idx]) for SCAN_DIV cycles. On the last cycle: if idx=NUM_DIGITS-1, set idx=0 and raise frame boundary; else idx+1. Then go to BLANK (or SHOW).
- enable=0 in any state -> IDLE on the next edge; outputs off on that edge; idx and counter cleared. Buffers are kept.
- Frame length = NUM_DIGITS*(SCAN_DIV+BLANK_CYCLES) cycles.
- Double buffering:
  - load=1 -> pending<=digits, dp_in; pending_valid<=1. Repeated loads overwrite pending.
  - active updates only at a frame boundary, so the display never tears within a frame.
  - At a boundary: active <= load ? current inputs : pending_valid ? pending : active. pending_valid clears.
  - load coincident with the boundary bypasses pending (same-cycle value wins).
  - Load while in IDLE: active <= inputs immediately, so the first frame after enable shows the latest value.
- frame_done: high exactly one cycle, on the edge that leaves SHOW of the last digit.
- Counter width: $clog2(max(SCAN_DIV, BLANK_CYCLES)+1).

Optional Feature:
SEG7_LZB_EN
- Defined: leading-zero blanking. Digit i>0 is blanked (seg all-off, an still asserted to keep timing) when active[i] and every higher digit are 0 and dp for all of them is 0. Digit 0 is never blanked.
- Undefined: every digit is always decoded.

Decomposition:
- Package seg7_pkg: segment code constants (SEG_OFF and codes 0-F), state enum {IDLE, BLANK, SHOW}, decode function.
- One natural sub-module: seg7_decode (nibble + dp + hex_mode -> 8-bit seg, combinational), instantiated once on the muxed nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, polarity params 0.
- Reset then enable=1, digits=16'h1234, load in IDLE -> 20-cycle frame. an=0001/seg=01100110 (4), then 0010/11110010, 0100/11011010, 1000/01100000, each for 4 cycles with 1 off cycle between. frame_done pulses every 20 cycles.
- load 16'h5678 mid-frame (cycle 7) -> current frame still shows 1234; next frame shows 5678; no mixed frame.
- load coincident with frame_done edge carrying 16'h9ABC, with an earlier pending 16'h1111 -> next frame shows 9ABC. With HEX_MODE=0, digits A-C are blank.
- enable dropped during SHOW of idx=2 -> next edge an=0000, seg=0; re-enable restarts at idx=0 with an off BLANK cycle first.
- rst_n asserted mid-SHOW -> seg/an go off asynchronously before the next clk edge; active buffer reads 0 after release.
- With SEG7_LZB_EN, digits=16'h0070, dp=0 -> digits 3 and 2 blanked, 1 shows 7 (11100100), 0 shows 0 (11111100). dp_in=4'b1000 -> digit 3 shows 0 with dp.
